// File: rtl/tqvp_arb_pkg.sv
// Shared types and constants for the two-requester register bus arbiter.
// Optional ownership lock is enabled by TQV_ARB_LOCK_EN.
package tqvp_arb_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'b00,
    StAccess = 2'b01,
    StResp   = 2'b10
  } arb_state_e;

  localparam logic REQ_SPI = 1'b0;
  localparam logic REQ_SEQ = 1'b1;

endpackage

// File: rtl/tqvp_rr_pick.sv
// Combinational two-way round-robin picker.
// With TQV_ARB_LOCK_EN a held lock restricts the grant to the locked owner.
module tqvp_rr_pick import tqvp_arb_pkg::*; (
  input  logic [1:0] req,
  input  logic       last_grant,
`ifdef TQV_ARB_LOCK_EN
  input  logic       lock_active,
  input  logic       lock_owner,
`endif
  output logic       grant_valid,
  output logic       grant_idx
);

  always_comb begin
    grant_valid = |req;
    grant_idx   = REQ_SPI;
    if (req[REQ_SPI] && req[REQ_SEQ]) begin
      grant_idx = ~last_grant;
    end else if (req[REQ_SEQ]) begin
      grant_idx = REQ_SEQ;
    end
`ifdef TQV_ARB_LOCK_EN
    // A locked owner excludes the other requester entirely.
    if (lock_active) begin
      grant_valid = req[lock_owner];
      grant_idx   = lock_owner;
    end
`endif
  end

endmodule

// File: rtl/tqvp_reg_bus_arbiter.sv
// Round-robin arbiter/sequencer sharing one peripheral register port between two requesters.
// Each access is a fixed IDLE -> ACCESS -> RESP sequence; TQV_ARB_LOCK_EN adds ownership lock.
module tqvp_reg_bus_arbiter import tqvp_arb_pkg::*; #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              ack0,
  output logic              ack1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
`ifdef TQV_ARB_LOCK_EN
  input  logic              lock0,
  input  logic              lock1,
`endif
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] data_in,
  output logic              data_write,
  input  logic [DATA_W-1:0] data_out,
  output logic              busy,
  output logic              owner
);

  arb_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q;
  logic              owner_q;
  logic              last_grant_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic              grant_valid, grant_idx;
  logic              take_grant;
`ifdef TQV_ARB_LOCK_EN
  logic              lock_active_q;
`endif

  tqvp_rr_pick u_pick (
    .req         ({req1, req0}),
    .last_grant  (last_grant_q),
`ifdef TQV_ARB_LOCK_EN
    .lock_active (lock_active_q),
    .lock_owner  (owner_q),
`endif
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign take_grant = (state_q == StIdle) && grant_valid;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (grant_valid) state_d = StAccess;
      StAccess: state_d = StResp;
      StResp:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      addr_q        <= '0;
      wdata_q       <= '0;
      we_q          <= 1'b0;
      owner_q       <= REQ_SPI;
      last_grant_q  <= REQ_SEQ;  // requester 0 wins the first tie
      rdata0_q      <= '0;
      rdata1_q      <= '0;
`ifdef TQV_ARB_LOCK_EN
      lock_active_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      if (take_grant) begin
        addr_q       <= (grant_idx == REQ_SEQ) ? addr1  : addr0;
        wdata_q      <= (grant_idx == REQ_SEQ) ? wdata1 : wdata0;
        we_q         <= (grant_idx == REQ_SEQ) ? we1    : we0;
        owner_q      <= grant_idx;
        last_grant_q <= grant_idx;
      end
      // Captured on writes too, so rdata reflects the post-write register value.
      if (state_q == StAccess) begin
        if (owner_q == REQ_SEQ) rdata1_q <= data_out;
        else                    rdata0_q <= data_out;
      end
`ifdef TQV_ARB_LOCK_EN
      if (state_q == StResp) begin
        lock_active_q <= (owner_q == REQ_SEQ) ? lock1 : lock0;
      end
`endif
    end
  end

  assign address    = addr_q;
  assign data_in    = wdata_q;
  assign data_write = (state_q == StAccess) && we_q;
  assign busy       = (state_q != StIdle);
  assign owner      = owner_q;
  assign ack0       = (state_q == StResp) && (owner_q == REQ_SPI);
  assign ack1       = (state_q == StResp) && (owner_q == REQ_SEQ);
  assign rdata0     = rdata0_q;
  assign rdata1     = rdata1_q;

endmodule

// File: tb/tb_tqvp_reg_bus_arbiter.sv
// Directed bench for tqvp_reg_bus_arbiter; lock scenario runs only with TQV_ARB_LOCK_EN.
module tb_tqvp_reg_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1, we0, we1;
  logic [3:0] addr0, addr1;
  logic [7:0] wdata0, wdata1;
  logic       ack0, ack1;
  logic [7:0] rdata0, rdata1;
`ifdef TQV_ARB_LOCK_EN
  logic       lock0, lock1;
`endif
  logic [3:0] address;
  logic [7:0] data_in;
  logic       data_write;
  logic [7:0] data_out;
  logic       busy, owner;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  tqvp_reg_bus_arbiter #(.ADDR_W(4), .DATA_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0       (req0),
    .req1       (req1),
    .we0        (we0),
    .we1        (we1),
    .addr0      (addr0),
    .addr1      (addr1),
    .wdata0     (wdata0),
    .wdata1     (wdata1),
    .ack0       (ack0),
    .ack1       (ack1),
    .rdata0     (rdata0),
    .rdata1     (rdata1),
`ifdef TQV_ARB_LOCK_EN
    .lock0      (lock0),
    .lock1      (lock1),
`endif
    .address    (address),
    .data_in    (data_in),
    .data_write (data_write),
    .data_out   (data_out),
    .busy       (busy),
    .owner      (owner)
  );

  // Peripheral: fixed register contents, writes visible combinationally.
  always_comb begin
    if (data_write) begin
      data_out = data_in;
    end else begin
      case (address)
        4'h1:    data_out = 8'h11;
        4'h2:    data_out = 8'h22;
        4'h5:    data_out = 8'h3C;
        default: data_out = 8'h00;
      endcase
    end
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    req0 = 1'b1; req1 = 1'b1; we0 = 1'b1; we1 = 1'b1;
    addr0 = 4'h9; addr1 = 4'hA; wdata0 = 8'hFF; wdata1 = 8'hEE;
`ifdef TQV_ARB_LOCK_EN
    lock0 = 1'b0; lock1 = 1'b0;
`endif

    // Reset with requests driven
    repeat (3) tick();
    check_val("rst_address", 32'(address), 32'h0);
    check_val("rst_data_in", 32'(data_in), 32'h0);
    check_val("rst_data_write", 32'(data_write), 32'h0);
    check_val("rst_ack", 32'({ack1, ack0}), 32'h0);
    check_val("rst_rdata0", 32'(rdata0), 32'h0);
    check_val("rst_rdata1", 32'(rdata1), 32'h0);
    check_val("rst_busy", 32'(busy), 32'h0);
    check_val("rst_owner", 32'(owner), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick();
    check_val("post_rst_busy", 32'(busy), 32'h0);

    // Write from requester 0
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h3; wdata0 = 8'hA5;
    tick();
    check_val("wr_strobe", 32'(data_write), 32'h1);
    check_val("wr_address", 32'(address), 32'h3);
    check_val("wr_data_in", 32'(data_in), 32'hA5);
    check_val("wr_owner", 32'(owner), 32'h0);
    check_val("wr_ack_early", 32'(ack0), 32'h0);
    tick();
    check_val("wr_strobe_off", 32'(data_write), 32'h0);
    check_val("wr_ack0", 32'(ack0), 32'h1);
    check_val("wr_ack1", 32'(ack1), 32'h0);
    check_val("wr_rdata0", 32'(rdata0), 32'hA5);
    check_val("wr_rdata1", 32'(rdata1), 32'h0);
    req0 = 1'b0;
    tick();
    check_val("wr_ack_after", 32'(ack0), 32'h0);
    check_val("wr_idle", 32'(busy), 32'h0);
    check_val("wr_addr_hold", 32'(address), 32'h3);

    // Read from requester 1
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h5;
    tick();
    check_val("rd_strobe", 32'(data_write), 32'h0);
    check_val("rd_address", 32'(address), 32'h5);
    check_val("rd_owner", 32'(owner), 32'h1);
    tick();
    check_val("rd_ack1", 32'(ack1), 32'h1);
    check_val("rd_ack0", 32'(ack0), 32'h0);
    check_val("rd_rdata1", 32'(rdata1), 32'h3C);
    check_val("rd_rdata0_kept", 32'(rdata0), 32'hA5);
    req1 = 1'b0;
    tick();
    check_val("rd_idle", 32'(busy), 32'h0);

    // Contention: four back-to-back transactions alternate owners
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1;
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("ct_owner", 32'(owner), 32'(k % 2));
      check_val("ct_busy", 32'(busy), 32'h1);
      tick();
      check_val("ct_ack0", 32'(ack0), 32'((k % 2) == 0));
      check_val("ct_ack1", 32'(ack1), 32'((k % 2) == 1));
      if (k == 3) begin
        req0 = 1'b0; req1 = 1'b0;
      end
      tick();
      check_val("ct_gap", 32'({ack1, ack0, busy}), 32'h0);
    end
    check_val("ct_rdata0", 32'(rdata0), 32'h11);
    check_val("ct_rdata1", 32'(rdata1), 32'h22);

    // Reset during the ACCESS cycle of a requester-0 write
    req0 = 1'b1; we0 = 1'b1; addr0 = 4'h7; wdata0 = 8'h5A;
    tick();
    check_val("mr_strobe", 32'(data_write), 32'h1);
    #2;
    rst_n = 1'b0; req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
    #1;
    check_val("mr_strobe_async", 32'(data_write), 32'h0);
    check_val("mr_busy", 32'(busy), 32'h0);
    check_val("mr_address", 32'(address), 32'h0);
    check_val("mr_rdata0", 32'(rdata0), 32'h0);
    repeat (2) begin
      tick();
      check_val("mr_no_ack", 32'({ack1, ack0}), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check_val("mr_tie_owner", 32'(owner), 32'h0);
    check_val("mr_tie_address", 32'(address), 32'h7);
    tick();
    check_val("mr_tie_ack0", 32'(ack0), 32'h1);
    check_val("mr_tie_ack1", 32'(ack1), 32'h0);
    req0 = 1'b0; req1 = 1'b0;
    tick();

`ifdef TQV_ARB_LOCK_EN
    // Lock: requester 0 keeps ownership for three locked transactions
    req0 = 1'b1; we0 = 1'b0; addr0 = 4'h1; lock0 = 1'b1;
    tick();
    req1 = 1'b1; we1 = 1'b0; addr1 = 4'h2;
    for (int k = 0; k < 4; k++) begin
      check_val("lk_owner", 32'(owner), 32'h0);
      if (k == 3) lock0 = 1'b0;
      tick();
      check_val("lk_ack0", 32'(ack0), 32'h1);
      check_val("lk_ack1", 32'(ack1), 32'h0);
      tick();
      tick();
    end
    check_val("lk_release_owner", 32'(owner), 32'h1);
    tick();
    check_val("lk_release_ack1", 32'(ack1), 32'h1);
    req0 = 1'b0; req1 = 1'b0;
    tick();
    tick();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tqvp_reg_bus_arbiter.md
# tqvp_reg_bus_arbiter

Two-requester arbiter and sequencer for the peripheral register port: 4-bit `address`, 8-bit `data_in` (write data), `data_write` strobe and 8-bit `data_out` (read data). It lets the SPI register host (requester 0) and a local command sequencer (requester 1) share one peripheral. Each access runs as a fixed 3-cycle transaction with round-robin arbitration. It sits between the SPI register block and the user peripheral inside the test harness.

## Interface
Parameters:
- `ADDR_W`, default 4, register address width.
- `DATA_W`, default 8, register data width.

Ports:
- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0` / `req1`  in  1  transaction request; held with fields stable until ack.
- `we0` / `we1`  in  1  1 = write, 0 = read.
- `addr0` / `addr1`  in  ADDR_W  register address.
- `wdata0` / `wdata1`  in  DATA_W  write data.
- `ack0` / `ack1`  out  1  one-cycle completion pulse.
- `rdata0` / `rdata1`  out  DATA_W  registered read data, valid with ack and held after it.
- `lock0` / `lock1`  in  1  hold ownership; present only with `TQV_ARB_LOCK_EN`.
- `address`  out  ADDR_W  to peripheral.
- `data_in`  out  DATA_W  write data to peripheral.
- `data_write`  out  1  peripheral write strobe.
- `data_out`  in  DATA_W  read data from peripheral, combinational on `address`.
- `busy`  out  1  high in ACCESS or RESP.
- `owner`  out  1  index of the current or last granted requester.

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If any `req` is high, pick a winner and register `address`, `data_in`, `we` and `owner`. Go to ACCESS.
  - If no `req` is high, stay in IDLE.
- ACCESS:
  - `data_write` = registered `we`.
  - At the end of the cycle, capture `data_out` into the owner's `rdata`. This happens for writes too, so `rdata` then holds the post-write value. Go to RESP.
- RESP:
  - Owner's `ack` = 1. Both `req` inputs are ignored. Go to IDLE.
- Round-robin rule: when both requesters are requesting, grant the one that is not `last_grant`. `last_grant` updates on every grant. When only one requests, grant it.
- `address` and `data_in` hold their last values in IDLE. `data_write` is 0 outside ACCESS.
- Requester rule: deassert `req` on the edge that samples `ack`. A `req` that stays high after that edge is treated as a new transaction.
- Non-owner `ack` is always 0. The non-owner's `rdata` is unchanged.

## Timing
- Reset values: all outputs 0, state IDLE, `last_grant` = 1 (so requester 0 wins the first tie).
- Cycle N (IDLE, `req` seen) → N+1 ACCESS (bus valid, strobe) → N+2 RESP (`ack`, `rdata` valid).
- Request-to-ack latency: 2 cycles. Maximum throughput: 1 transaction per 3 cycles.
- Worst-case wait for a contending requester: 3 cycles (one transaction of the other requester), unless lock is enabled.
- Reset mid-transaction: all outputs clear asynchronously. `data_write` drops without waiting for a clock edge, no `ack` is issued, and the FSM returns to IDLE. After reset release, the first tie goes to requester 0.
- A request arriving while in ACCESS or RESP waits; it is evaluated in the next IDLE cycle.

## Configuration
- `TQV_ARB_LOCK_EN` defined:
  - `lock0` and `lock1` ports exist.
  - If the owner's `lock` is high in RESP, ownership is retained: in the following IDLE cycles only the owner's `req` is considered, and `last_grant` is not used.
  - Lock releases after the owner completes a transaction with `lock` = 0 in RESP.
  - Reset clears the lock.
- `TQV_ARB_LOCK_EN` undefined: the lock ports are absent and arbitration is pure round-robin.

## Structure
- Package `tqvp_arb_pkg` holds:
  - the state encoding (IDLE=2'b00, ACCESS=2'b01, RESP=2'b10);
  - requester index constants `REQ_SPI` = 0 and `REQ_SEQ` = 1.
- Sub-module `tqvp_rr_pick`: combinational two-way round-robin picker. Inputs: `req[1:0]`, `last_grant`, and lock state when enabled. Outputs: `grant_valid`, `grant_idx`.
- The top level holds the FSM, the bus registers and the `rdata`/`ack` registers.

## Test plan
- Reset: hold `rst_n` low with requests driven → all outputs 0. After release, `busy` = 0.
- Write: `req0`, `we0`=1, `addr0`=4'h3, `wdata0`=8'hA5 → in cycle N+1, `data_write`=1 with `address`=3 and `data_in`=A5 for exactly 1 cycle. `ack0`=1 in cycle N+2 only.
- Read: `req1`, `we1`=0, `addr1`=4'h5, peripheral `data_out`=8'h3C → `ack1` and `rdata1`=3C in cycle N+2. `data_write` is never high.
- Contention: both requesters hold `req` for 4 transactions → owners 0,1,0,1. `ack` pulses are exactly 3 cycles apart.
- Reset during ACCESS of a write → `data_write` falls immediately without a clock edge. No `ack`. After release, the first tie is granted to requester 0.
- With `TQV_ARB_LOCK_EN` defined: `lock0`=1 for 3 transactions while `req1` is held → `req1` is not granted. Requester 0's fourth transaction runs with `lock0`=0, and `req1` is granted in the next IDLE.
